// File: rtl/phase_window_counter.sv
// Per-channel pulse counter over a programmable window. Counts saturate, and
// the results drain one channel at a time over a valid/ready handshake.
module phase_window_counter #(
    parameter int unsigned PHASE_WIDTH = 11,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned WIN_WIDTH   = 16,
    parameter int unsigned CH_WIDTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [WIN_WIDTH-1:0]   win_len_i,
    input  logic [PHASE_WIDTH-1:0] pulse_i,
    output logic                   busy_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [CNT_WIDTH-1:0]   data_o,
    output logic [CH_WIDTH-1:0]    ch_o,
    output logic                   done_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CH_WIDTH-1:0]  LAST_CH = CH_WIDTH'(PHASE_WIDTH - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q [PHASE_WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [PHASE_WIDTH];
    logic [WIN_WIDTH-1:0] win_q, win_d;
    logic [CH_WIDTH-1:0]  idx_q, idx_d;
    logic                 busy_d, valid_d, done_d;
    logic [CNT_WIDTH-1:0] data_d;
    logic [CH_WIDTH-1:0]  ch_d;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            for (int unsigned i = 0; i < PHASE_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            win_q   <= '0;
            idx_q   <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            data_o  <= '0;
            ch_o    <= '0;
        end else begin
            state_q <= state_d;
            for (int unsigned i = 0; i < PHASE_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            win_q   <= win_d;
            idx_q   <= idx_d;
            busy_o  <= busy_d;
            valid_o <= valid_d;
            done_o  <= done_d;
            data_o  <= data_d;
            ch_o    <= ch_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    for (int unsigned i = 0; i < PHASE_WIDTH; i++) begin
                        cnt_d[i] = '0;
                    end
                    win_d   = win_len_i;
                    idx_d   = '0;
                    state_d = (win_len_i == '0) ? ST_DRAIN : ST_COUNT;
                end
            end
            ST_COUNT: begin
                for (int unsigned i = 0; i < PHASE_WIDTH; i++) begin
                    if (pulse_i[i] && (cnt_q[i] != CNT_MAX)) begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
                // win_q counts the remaining window cycles including this one
                win_d = win_q - WIN_WIDTH'(1);
                if (win_q == WIN_WIDTH'(1)) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (valid_o && ready_i) begin
                    if (idx_q == LAST_CH) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + CH_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DRAIN);
        data_d  = valid_d ? cnt_d[idx_d] : '0;
        ch_d    = valid_d ? idx_d : '0;
    end

endmodule

// File: tb/tb_phase_window_counter.sv
// Directed bench for phase_window_counter: expected transfers are queued at
// stimulus time and a negedge monitor checks each handshake against them.
module tb_phase_window_counter;

    localparam int unsigned PW  = 11;
    localparam int unsigned CW  = 4;
    localparam int unsigned WW  = 16;
    localparam int unsigned CHW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic [WW-1:0]  win_len_i;
    logic [PW-1:0]  pulse_i;
    logic           busy_o;
    logic           valid_o;
    logic           ready_i;
    logic [CW-1:0]  data_o;
    logic [CHW-1:0] ch_o;
    logic           done_o;

    always #5 clk = ~clk;

    phase_window_counter #(
        .PHASE_WIDTH(PW),
        .CNT_WIDTH  (CW),
        .WIN_WIDTH  (WW),
        .CH_WIDTH   (CHW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .win_len_i(win_len_i),
        .pulse_i  (pulse_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .ch_o     (ch_o),
        .done_o   (done_o)
    );

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [CW-1:0]  data;
    } xfer_t;

    int            checks = 0;
    int            errors = 0;
    xfer_t         sb[$];
    logic [PW-1:0] pv[$];
    int            exp_cnt[PW];
    int            ready_mode = 0;
    logic          exp_done = 1'b0;
    logic          stalled = 1'b0;
    xfer_t         held;
    xfer_t         want;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_exp();
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
    endtask

    // Monitor: pops one expected transfer per handshake, checks stalls and done_o
    initial begin
        forever begin
            @(negedge clk);
            check("done_o", 32'(done_o), 32'(exp_done));
            if (stalled) begin
                check("stall_valid", 32'(valid_o), 32'd1);
                check("stall_ch", 32'(ch_o), 32'(held.ch));
                check("stall_data", 32'(data_o), 32'(held.data));
            end
            exp_done = 1'b0;
            stalled  = 1'b0;
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer actual=ch%0d/%0h required=none @%0t",
                             ch_o, data_o, $time);
                end else begin
                    want = sb.pop_front();
                    check("xfer_ch", 32'(ch_o), 32'(want.ch));
                    check("xfer_data", 32'(data_o), 32'(want.data));
                end
                exp_done = (ch_o == CHW'(PW - 1));
            end else if (valid_o === 1'b1) begin
                stalled = 1'b1;
                held    = {ch_o, data_o};
            end
        end
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = hold low
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b0;
            endcase
        end
    end

    task automatic push_exp();
        for (int i = 0; i < int'(PW); i++) begin
            sb.push_back({CHW'(i), CW'(exp_cnt[i])});
        end
    endtask

    // Start a measurement, drive pv during the window, and enter DRAIN
    task automatic run(input int n, input logic [PW-1:0] start_pulse,
                       input logic [PW-1:0] after_pulse);
        push_exp();
        start_i   = 1'b1;
        win_len_i = WW'(n);
        pulse_i   = start_pulse;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int c = 0; c < n; c++) begin
            check("count_busy", 32'(busy_o), 32'd1);
            check("count_valid", 32'(valid_o), 32'd0);
            pulse_i = (c < pv.size()) ? pv[c] : '0;
            @(posedge clk);
            #1;
        end
        check("drain_valid", 32'(valid_o), 32'd1);
        check("drain_ch0", 32'(ch_o), 32'd0);
        check("drain_busy", 32'(busy_o), 32'd1);
        pulse_i = after_pulse;
        @(posedge clk);
        #1;
        pulse_i = '0;
    endtask

    // Returns in the done_o cycle
    task automatic wait_done();
        int k = 0;
        while (done_o !== 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_seen", 32'(done_o), 32'd1);
        check("done_busy", 32'(busy_o), 32'd0);
        check("done_valid", 32'(valid_o), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        start_i   = 1'b0;
        win_len_i = '0;
        pulse_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ch", 32'(ch_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a 100-cycle window with all channels pulsing
        start_i   = 1'b1;
        win_len_i = WW'(100);
        pulse_i   = '1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("midcount_busy", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        check("async_busy", 32'(busy_o), 32'd0);
        check("async_valid", 32'(valid_o), 32'd0);
        check("async_done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        pulse_i = '0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        clear_exp();
        pv.delete();
        run(4, '0, '0);
        wait_done();

        // Basic count: ch0 every cycle, ch3 on alternate cycles
        clear_exp();
        exp_cnt[0] = 10;
        exp_cnt[3] = 5;
        pv.delete();
        for (int c = 0; c < 10; c++) begin
            pv.push_back(PW'(1) | (((c % 2) == 0) ? PW'(8) : PW'(0)));
        end
        run(10, '0, '0);
        wait_done();

        // Window edges: only the first and last window cycles count
        clear_exp();
        exp_cnt[1] = 2;
        pv.delete();
        pv.push_back(PW'(2));
        pv.push_back(PW'(0));
        pv.push_back(PW'(0));
        pv.push_back(PW'(0));
        pv.push_back(PW'(2));
        run(5, PW'(2), PW'(2));
        wait_done();

        // Backpressure with random ready
        clear_exp();
        for (int i = 0; i < int'(PW); i++) begin
            exp_cnt[i] = 1 + (((i % 2) == 0) ? 1 : 0) + ((i == 10) ? 1 : 0);
        end
        pv.delete();
        pv.push_back('1);
        pv.push_back(PW'(11'b101_0101_0101));
        pv.push_back(PW'(11'b100_0000_0000));
        ready_mode = 1;
        run(3, '0, '0);
        wait_done();
        ready_mode = 0;

        // Saturation at 15: ch2 for 20 cycles, ch5 for 15, ch6 for 14
        clear_exp();
        exp_cnt[2] = 15;
        exp_cnt[5] = 15;
        exp_cnt[6] = 14;
        pv.delete();
        for (int c = 0; c < 20; c++) begin
            pv.push_back(PW'(4) | ((c < 15) ? PW'(32) : PW'(0)) | ((c < 14) ? PW'(64) : PW'(0)));
        end
        run(20, '0, '0);
        wait_done();

        // Zero-length window: pulses around it must not count
        clear_exp();
        pv.delete();
        run(0, '1, '1);
        wait_done();

        // Start ignored during COUNT and DRAIN
        clear_exp();
        exp_cnt[4] = 6;
        push_exp();
        start_i   = 1'b1;
        win_len_i = WW'(6);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            pulse_i   = PW'(16);
            start_i   = (c == 2);
            win_len_i = (c == 2) ? WW'(2) : WW'(6);
            if (c == 5) ready_mode = 2;
            @(posedge clk);
            #1;
        end
        start_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("stall_busy", 32'(busy_o), 32'd1);
            check("stall_hold_valid", 32'(valid_o), 32'd1);
            check("stall_hold_ch", 32'(ch_o), 32'd0);
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        ready_mode = 0;
        pulse_i    = '0;
        wait_done();

        // Start in the done_o cycle is accepted
        clear_exp();
        exp_cnt[7] = 2;
        pv.delete();
        pv.push_back(PW'(128));
        pv.push_back(PW'(128));
        run(2, '0, '0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
